// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes, opcodes,
// ALU/datapath select values and the per-state Moore control bundle.
package multicycle_control_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      RCOMPL = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      ADDIEX = 4'd10,
      ADDIWB = 4'd11,
      TRAP   = 4'd12
   } stateT;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_BRANCH = 2'b11;

   localparam logic [1:0] PCSRC_ALU  = 2'b00;
   localparam logic [1:0] PCSRC_OUT  = 2'b01;
   localparam logic [1:0] PCSRC_JUMP = 2'b10;

   typedef struct packed {
      logic       fetch;
      logic       pcWrite;
      logic       pcWriteCond;
      logic       iorD;
      logic       memRead;
      logic       memWrite;
      logic       memtoReg;
      logic       aluSrcA;
      logic       regWrite;
      logic       regDst;
      logic [1:0] pcSource;
      logic [1:0] aluOp;
      logic [1:0] aluSrcB;
   } ctrlT;

   // Unlisted strobes stay 0 and unlisted selects stay 00; TRAP decodes to all zeros.
   function automatic ctrlT decodeState(stateT s);
      ctrlT c;
      c = '0;
      case (s)
         FETCH: begin
            c.fetch    = 1'b1;
            c.memRead  = 1'b1;
            c.aluSrcB  = SRCB_FOUR;
            c.aluOp    = ALUOP_ADD;
            c.pcSource = PCSRC_ALU;
         end
         DECODE: c.aluSrcB = SRCB_BRANCH;
         MEMADR, ADDIEX: begin
            c.aluSrcA = 1'b1;
            c.aluSrcB = SRCB_IMM;
         end
         MEMRD: begin
            c.memRead = 1'b1;
            c.iorD    = 1'b1;
         end
         MEMWB: begin
            c.regWrite = 1'b1;
            c.memtoReg = 1'b1;
         end
         MEMWR: begin
            c.memWrite = 1'b1;
            c.iorD     = 1'b1;
         end
         EXEC: begin
            c.aluSrcA = 1'b1;
            c.aluSrcB = SRCB_REG;
            c.aluOp   = ALUOP_FUNCT;
         end
         RCOMPL: begin
            c.regWrite = 1'b1;
            c.regDst   = 1'b1;
         end
         BRANCH: begin
            c.aluSrcA     = 1'b1;
            c.aluOp       = ALUOP_SUB;
            c.pcWriteCond = 1'b1;
            c.pcSource    = PCSRC_OUT;
         end
         JUMP: begin
            c.pcWrite  = 1'b1;
            c.pcSource = PCSRC_JUMP;
         end
         ADDIWB: c.regWrite = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with registered Moore strobes, memory-wait
// timeout detection, illegal-opcode trap and a fetched-instruction counter.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  Op,
   input  logic        memReady,
   output logic        PCWrite,
   output logic        PCWriteCond,
   output logic        IorD,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        MemtoReg,
   output logic        IRWrite,
   output logic        ALUSrcA,
   output logic        RegWrite,
   output logic        RegDst,
   output logic [1:0]  PCSource,
   output logic [1:0]  ALUOp,
   output logic [1:0]  ALUSrcB,
   output logic [3:0]  state,
   output logic        illegalOp,
   output logic        memTimeout,
   output logic [31:0] instrCount
);

   localparam logic [3:0] WAIT_LIMIT = 4'(MEM_WAIT_MAX);

   stateT      curState;
   stateT      nextState;
   ctrlT       ctrl;
   logic       fetchGo;
   logic       memWait;
   logic [3:0] waitCount;
   logic [3:0] waitInc;

   // ctrl.fetch only rises on the first edge after reset release, so a fetch can
   // never complete while the strobes are still forced low by reset.
   assign fetchGo = ctrl.fetch & memReady;
   assign memWait = ~memReady & (ctrl.fetch | (curState == MEMRD) | (curState == MEMWR));
   assign waitInc = waitCount + 4'd1;

   // Next-state selection; unreachable encodings fall into TRAP.
   always_comb begin
      nextState = curState;
      case (curState)
         FETCH:  if (fetchGo) nextState = DECODE;
         DECODE: begin
            case (Op)
               OP_R:         nextState = EXEC;
               OP_LW, OP_SW: nextState = MEMADR;
               OP_BEQ:       nextState = BRANCH;
               OP_J:         nextState = JUMP;
               OP_ADDI:      nextState = ADDIEX;
               default:      nextState = TRAP;
            endcase
         end
         MEMADR: begin
            if (Op == OP_LW)      nextState = MEMRD;
            else if (Op == OP_SW) nextState = MEMWR;
            else                  nextState = TRAP;
         end
         MEMRD:  if (memReady) nextState = MEMWB;
         MEMWR:  if (memReady) nextState = FETCH;
         EXEC:   nextState = RCOMPL;
         ADDIEX: nextState = ADDIWB;
         MEMWB, RCOMPL, BRANCH, JUMP, ADDIWB: nextState = FETCH;
         TRAP:   nextState = TRAP;
         default: nextState = TRAP;
      endcase
   end

   // State and strobes register together, so the outputs always match the state code.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         curState  <= FETCH;
         ctrl      <= '0;
         illegalOp <= 1'b0;
      end else begin
         curState <= nextState;
         ctrl     <= decodeState(nextState);
         if (nextState == TRAP) illegalOp <= 1'b1;
      end
   end

   // Consecutive stall cycles in a memory-wait state; the flag stays set once raised.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         waitCount  <= 4'd0;
         memTimeout <= 1'b0;
      end else begin
         if ((nextState != curState) || !memWait) waitCount <= 4'd0;
         else if (waitCount != 4'hF)              waitCount <= waitInc;
         if (memWait && (waitInc == WAIT_LIMIT)) memTimeout <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       instrCount <= 32'd0;
      else if (fetchGo) instrCount <= instrCount + 32'd1;
   end

   assign PCWrite     = ctrl.pcWrite | fetchGo;
   assign IRWrite     = fetchGo;
   assign PCWriteCond = ctrl.pcWriteCond;
   assign IorD        = ctrl.iorD;
   assign MemRead     = ctrl.memRead;
   assign MemWrite    = ctrl.memWrite;
   assign MemtoReg    = ctrl.memtoReg;
   assign ALUSrcA     = ctrl.aluSrcA;
   assign RegWrite    = ctrl.regWrite;
   assign RegDst      = ctrl.regDst;
   assign PCSource    = ctrl.pcSource;
   assign ALUOp       = ctrl.aluOp;
   assign ALUSrcB     = ctrl.aluSrcB;
   assign state       = curState;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instruction scenarios then random
// opcode/memReady traffic, checked against a per-instruction path model.
module tb_multicycle_control;

   localparam int MEM_WAIT_MAX = 15;
   localparam logic [5:0] R_OP = 6'b000000, LW_OP = 6'b100011, SW_OP = 6'b101011;
   localparam logic [5:0] BEQ_OP = 6'b000100, J_OP = 6'b000010, ADDI_OP = 6'b001000;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  Op;
   logic        memReady;
   logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
   logic        IRWrite, ALUSrcA, RegWrite, RegDst;
   logic [1:0]  PCSource, ALUOp, ALUSrcB;
   logic [3:0]  state;
   logic        illegalOp, memTimeout;
   logic [31:0] instrCount;
   logic [15:0] obsStrobes;

   int          vectors = 0;
   int          miscompares = 0;
   int          expState;
   logic [31:0] expCount;
   logic        expIllegal, expTimeout, armed;
   int          stallRun;
   int          path[$];
   logic [5:0]  legalOps[6] = '{R_OP, LW_OP, SW_OP, BEQ_OP, J_OP, ADDI_OP};
   logic [5:0]  randOp;
   int          trapCycles;

   always #5 clk = ~clk;

   multicycle_control #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
      .clk(clk), .reset(reset), .Op(Op), .memReady(memReady),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
      .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
      .ALUSrcB(ALUSrcB), .state(state), .illegalOp(illegalOp), .memTimeout(memTimeout),
      .instrCount(instrCount)
   );

   assign obsStrobes = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                        ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB};

   // Control table of each state; FETCH only drives once the FSM is out of reset.
   function automatic logic [15:0] expStrobes(int s, logic ready, logic isArmed);
      logic pcw, pcwc, iord, mr, mw, m2r, irw, srcA, rw, rd;
      logic [1:0] pcs, aop, srcB;
      {pcw, pcwc, iord, mr, mw, m2r, irw, srcA, rw, rd} = '0;
      pcs = 2'b00; aop = 2'b00; srcB = 2'b00;
      case (s)
         0: if (isArmed) begin mr = 1'b1; srcB = 2'b01; irw = ready; pcw = ready; end
         1: srcB = 2'b11;
         2, 10: begin srcA = 1'b1; srcB = 2'b10; end
         3: begin mr = 1'b1; iord = 1'b1; end
         4: begin rw = 1'b1; m2r = 1'b1; end
         5: begin mw = 1'b1; iord = 1'b1; end
         6: begin srcA = 1'b1; aop = 2'b10; end
         7: begin rw = 1'b1; rd = 1'b1; end
         8: begin srcA = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
         9: begin pcw = 1'b1; pcs = 2'b10; end
         11: rw = 1'b1;
         default: ;
      endcase
      return {pcw, pcwc, iord, mr, mw, m2r, irw, srcA, rw, rd, pcs, aop, srcB};
   endfunction

   // States an instruction visits after its FETCH, by opcode.
   task automatic loadPath(input logic [5:0] op);
      case (op)
         LW_OP:   path = '{1, 2, 3, 4};
         SW_OP:   path = '{1, 2, 5};
         R_OP:    path = '{1, 6, 7};
         BEQ_OP:  path = '{1, 8};
         J_OP:    path = '{1, 9};
         ADDI_OP: path = '{1, 10, 11};
         default: path = '{1, 12};
      endcase
   endtask

   task automatic modelReset();
      expState = 0; expCount = 32'd0; expIllegal = 1'b0; expTimeout = 1'b0;
      armed = 1'b0; stallRun = 0; path.delete();
   endtask

   // Predicts the effect of the coming rising edge from the current inputs.
   task automatic modelAdvance();
      if (!reset) return;
      if (!armed) begin armed = 1'b1; return; end
      if (expState == 12) return;
      if ((expState == 0 || expState == 3 || expState == 5) && !memReady) begin
         stallRun++;
         if (stallRun >= MEM_WAIT_MAX) expTimeout = 1'b1;
         return;
      end
      stallRun = 0;
      if (expState == 0) begin
         expCount = expCount + 32'd1;
         loadPath(Op);
      end
      expState = (path.size() > 0) ? path.pop_front() : 0;
      if (expState == 12) expIllegal = 1'b1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".strobes"}, {16'h0, obsStrobes}, {16'h0, expStrobes(expState, memReady, armed)});
      checkOutput({tag, ".state"}, {28'h0, state}, 32'(expState));
      checkOutput({tag, ".instrCount"}, instrCount, expCount);
      checkOutput({tag, ".illegalOp"}, {31'h0, illegalOp}, {31'h0, expIllegal});
      checkOutput({tag, ".memTimeout"}, {31'h0, memTimeout}, {31'h0, expTimeout});
   endtask

   task automatic applyStimulus(input string tag, input logic [5:0] op, input logic ready);
      @(negedge clk);
      Op = op;
      memReady = ready;
      #1 checkAll(tag);
      modelAdvance();
   endtask

   // Called right after applyStimulus, so reset falls between clock edges.
   task automatic pulseReset(input string tag);
      #1 reset = 1'b0;
      modelReset();
      #1 checkAll({tag, ".async"});
      @(negedge clk);
      #1 checkAll({tag, ".held"});
      #1 reset = 1'b1;
      modelAdvance();
   endtask

   initial begin
      reset = 1'b0; Op = 6'd0; memReady = 1'b0;
      modelReset();
      repeat (2) @(negedge clk);
      #1 checkAll("reset");
      #1 reset = 1'b1;
      modelAdvance();

      for (int i = 0; i < 5; i++) applyStimulus("lw", LW_OP, 1'b1);
      applyStimulus("lw.end", LW_OP, 1'b0);
      checkOutput("lw.count", instrCount, 32'd1);

      for (int i = 0; i < 3; i++) applyStimulus("beq", BEQ_OP, 1'b1);
      applyStimulus("beq.end", BEQ_OP, 1'b0);

      for (int i = 0; i < 3; i++) applyStimulus("sw", SW_OP, 1'b1);
      applyStimulus("sw.memwr", SW_OP, 1'b0);
      checkOutput("sw.inMemwr", {28'h0, state}, 32'd5);
      pulseReset("swReset");

      for (int i = 0; i < 16; i++) applyStimulus("stall", R_OP, 1'b0);
      checkOutput("stall.timeout", {31'h0, memTimeout}, 32'd1);
      applyStimulus("stall.rise", R_OP, 1'b1);
      applyStimulus("wrap.decode", R_OP, 1'b1);
      force dut.instrCount = 32'hFFFF_FFFF;
      #1 release dut.instrCount;
      expCount = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) applyStimulus("wrap", R_OP, 1'b1);
      applyStimulus("wrap.next", R_OP, 1'b1);
      checkOutput("wrap.count", instrCount, 32'd0);
      pulseReset("preTrap");

      for (int i = 0; i < 23; i++) applyStimulus("trap", 6'h3F, 1'($urandom_range(0, 1)));
      checkOutput("trap.illegal", {31'h0, illegalOp}, 32'd1);
      pulseReset("postTrap");

      randOp = R_OP;
      trapCycles = 0;
      for (int i = 0; i < 400; i++) begin
         if (expState == 0) begin
            if ($urandom_range(0, 39) == 0) randOp = 6'($urandom_range(48, 63));
            else                            randOp = legalOps[$urandom_range(0, 5)];
         end
         applyStimulus("rand", randOp, $urandom_range(0, 3) != 0);
         if (expState == 12) begin
            trapCycles++;
            if (trapCycles > 3) begin
               pulseReset("randReset");
               trapCycles = 0;
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
